// File: rtl/inner_product_mac.sv
// Single-precision dot-product engine: one shared multiplier and one shared adder
// iterate over NUM_ELEMENTS operand pairs with stb/ack handshakes on every interface.

module ipm_fp_unit #(
  parameter bit IS_ADD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic        a_stb,
  output logic        a_ack,
  input  logic [31:0] b,
  input  logic        b_stb,
  output logic        b_ack,
  output logic [31:0] z,
  output logic        z_stb,
  input  logic        z_ack
);
  logic [31:0] a_q, b_q;
  logic        have_a, have_b;

  // Round to nearest even; denormal results and operands are flushed to zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [24:0] m, input logic g, input logic st);
    logic [24:0]       r;
    logic signed [9:0] er;
    r  = m + 25'(g && (st || m[0]));
    er = e;
    if (r[24]) begin
      r  = r >> 1;
      er = er + 10'sd1;
    end
    if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (er <= 10'sd0) return {s, 31'd0};
    return {s, er[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    s = x[31] ^ y[31];
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0)) return 32'h7FC00000;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
      return (x[30:23] == 8'd0 || y[30:23] == 8'd0) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = 10'(x[30:23]) + 10'(y[30:23]) - 10'd127;
    if (p[47]) return fp_pack(s, e + 10'sd1, {1'b0, p[47:24]}, p[23], |p[22:0]);
    return fp_pack(s, e, {1'b0, p[46:23]}, p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]       a_op, b_op;
    logic [7:0]        d;
    logic [26:0]       ma, mb;
    logic [27:0]       s;
    logic signed [9:0] e;
    int                lz;
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0)) return 32'h7FC00000;
    if (x[30:23] == 8'hFF)
      return (y[30:23] == 8'hFF && x[31] != y[31]) ? 32'h7FC00000 : x;
    if (y[30:23] == 8'hFF) return y;
    if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? {x[31] & y[31], 31'd0} : y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin a_op = x; b_op = y; end
    else begin a_op = y; b_op = x; end
    d  = a_op[30:23] - b_op[30:23];
    ma = {1'b1, a_op[22:0], 3'b000};
    mb = {1'b1, b_op[22:0], 3'b000};
    if (d > 8'd26) mb = 27'd1;
    else mb = (mb >> d) | 27'(|(mb & ((27'd1 << d) - 27'd1)));
    s = (a_op[31] == b_op[31]) ? {1'b0, ma} + {1'b0, mb} : {1'b0, ma} - {1'b0, mb};
    e = 10'(a_op[30:23]);
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      lz = 0;
      for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
      s = s << lz;
      e = e - 10'(lz);
    end
    return fp_pack(a_op[31], e, {1'b0, s[26:3]}, s[2], |s[1:0]);
  endfunction

  assign a_ack = !reset && !have_a && !z_stb;
  assign b_ack = !reset && !have_b && !z_stb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      have_a <= 1'b0;
      have_b <= 1'b0;
      z      <= '0;
      z_stb  <= 1'b0;
    end else begin
      if (a_stb && a_ack) begin a_q <= a; have_a <= 1'b1; end
      if (b_stb && b_ack) begin b_q <= b; have_b <= 1'b1; end
      if (have_a && have_b) begin
        z      <= IS_ADD ? fp_add(a_q, b_q) : fp_mul(a_q, b_q);
        z_stb  <= 1'b1;
        have_a <= 1'b0;
        have_b <= 1'b0;
      end else if (z_stb && z_ack) begin
        z_stb <= 1'b0;
      end
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for an input vector pair
// FETCH | select element k, skip zero pairs, or finish when k reaches NUM_ELEMENTS
// MULT  | multiply row[k] * column[k]
// ADD   | accumulate the product
// OUT   | hold result until the consumer acknowledges
module inner_product_mac #(
  parameter int NUM_ELEMENTS = 4,
  parameter int SKIP_ZERO    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [32*NUM_ELEMENTS-1:0] row,
  input  logic [32*NUM_ELEMENTS-1:0] column,
  input  logic                      accumulate,
  input  logic                      in_i_stb,
  output logic                      in_i_ack,
  output logic [31:0]               out,
  output logic                      out_o_stb,
  input  logic                      out_o_ack,
  output logic                      busy
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, MULT = 3'd2, ADD = 3'd3, OUT = 3'd4;

  logic [2:0]                state;
  logic [4:0]                k;
  logic [32*NUM_ELEMENTS-1:0] row_q, col_q;
  logic [31:0]               acc, prod;
  logic [31:0]               mul_a, mul_b, mul_z, add_z;
  logic                      mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic                      add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
  logic                      sub_rst_q, sub_rst, skip;

  assign mul_a     = row_q[{k, 5'b0} +: 32];
  assign mul_b     = col_q[{k, 5'b0} +: 32];
  assign skip      = (SKIP_ZERO != 0) && (mul_a[30:0] == 31'd0 || mul_b[30:0] == 31'd0);
  assign mul_z_ack = (state == MULT) && mul_z_stb;
  assign add_z_ack = (state == ADD) && add_z_stb;
  assign busy      = (state != IDLE);
  assign sub_rst   = !rst || sub_rst_q;

  ipm_fp_unit #(.IS_ADD(1'b0)) u_mul (
    .clk(clk), .reset(sub_rst),
    .a(mul_a), .a_stb(mul_a_stb), .a_ack(mul_a_ack),
    .b(mul_b), .b_stb(mul_b_stb), .b_ack(mul_b_ack),
    .z(mul_z), .z_stb(mul_z_stb), .z_ack(mul_z_ack)
  );

  ipm_fp_unit #(.IS_ADD(1'b1)) u_add (
    .clk(clk), .reset(sub_rst),
    .a(prod), .a_stb(add_a_stb), .a_ack(add_a_ack),
    .b(acc), .b_stb(add_b_stb), .b_ack(add_b_ack),
    .z(add_z), .z_stb(add_z_stb), .z_ack(add_z_ack)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      row_q     <= '0;
      col_q     <= '0;
      acc       <= '0;
      prod      <= '0;
      out       <= '0;
      out_o_stb <= 1'b0;
      in_i_ack  <= 1'b0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      sub_rst_q <= 1'b1;
    end else begin
      sub_rst_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_i_stb && in_i_ack) begin
            row_q    <= row;
            col_q    <= column;
            acc      <= accumulate ? out : 32'h00000000;
            k        <= '0;
            in_i_ack <= 1'b0;
            state    <= FETCH;
          end else begin
            in_i_ack <= 1'b1;
          end
        end
        FETCH: begin
          if (k == 5'(NUM_ELEMENTS)) begin
            out       <= acc;
            out_o_stb <= 1'b1;
            state     <= OUT;
          end else if (skip) begin
            k <= k + 5'd1;
          end else begin
            mul_a_stb <= 1'b1;
            mul_b_stb <= 1'b1;
            state     <= MULT;
          end
        end
        MULT: begin
          if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
          if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
          if (mul_z_stb) begin
            prod      <= mul_z;
            add_a_stb <= 1'b1;
            add_b_stb <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
          if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
          if (add_z_stb) begin
            acc   <= add_z;
            k     <= k + 5'd1;
            state <= FETCH;
          end
        end
        OUT: begin
          if (out_o_ack) begin
            out_o_stb <= 1'b0;
            in_i_ack  <= 1'b1;
            sub_rst_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inner_product_mac.sv
// Directed bench for inner_product_mac: dot products, accumulation, zero skipping,
// output backpressure, mid-operation reset and element-count sweep.
module tb_inner_product_mac;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] row = '0, column = '0;
  logic         accumulate = 1'b0, in_i_stb = 1'b0, out_o_ack = 1'b0;
  logic         in_i_ack, out_o_stb, busy;
  logic [31:0]  out;

  logic [31:0]  r1 = '0, c1 = '0, out1;
  logic         stb1 = 1'b0, oack1 = 1'b0, iack1, ostb1, busy1;
  logic [511:0] r16 = '0, c16 = '0;
  logic [31:0]  out16;
  logic         stb16 = 1'b0, oack16 = 1'b0, iack16, ostb16, busy16;

  int checks = 0;
  int fails = 0;
  int mul_txn = 0, add_txn = 0, strobe_cycles = 0;

  localparam logic [31:0] F0 = 32'h00000000, F05 = 32'h3F000000, F1 = 32'h3F800000,
                          F2 = 32'h40000000, F3 = 32'h40400000, F4 = 32'h40800000,
                          F5 = 32'h40A00000, FN0 = 32'h80000000;

  always #5 clk = ~clk;

  inner_product_mac #(.NUM_ELEMENTS(4), .SKIP_ZERO(1)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .accumulate(accumulate),
    .in_i_stb(in_i_stb), .in_i_ack(in_i_ack), .out(out), .out_o_stb(out_o_stb),
    .out_o_ack(out_o_ack), .busy(busy)
  );

  inner_product_mac #(.NUM_ELEMENTS(1), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .row(r1), .column(c1), .accumulate(1'b0),
    .in_i_stb(stb1), .in_i_ack(iack1), .out(out1), .out_o_stb(ostb1),
    .out_o_ack(oack1), .busy(busy1)
  );

  inner_product_mac #(.NUM_ELEMENTS(16), .SKIP_ZERO(1)) dut16 (
    .clk(clk), .rst(rst), .row(r16), .column(c16), .accumulate(1'b0),
    .in_i_stb(stb16), .in_i_ack(iack16), .out(out16), .out_o_stb(ostb16),
    .out_o_ack(oack16), .busy(busy16)
  );

  // Sub-unit transaction counters observed on the shared multiplier/adder handshakes.
  always @(posedge clk) begin
    if (dut.u_mul.a_stb && dut.u_mul.a_ack) mul_txn <= mul_txn + 1;
    if (dut.u_add.a_stb && dut.u_add.a_ack) add_txn <= add_txn + 1;
    if (dut.u_mul.a_stb || dut.u_mul.b_stb || dut.u_add.a_stb || dut.u_add.b_stb)
      strobe_cycles <= strobe_cycles + 1;
  end

  function automatic logic [127:0] vec4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic start_op(input logic [127:0] r, input logic [127:0] c, input logic acc, output bit ok);
    int n = 0;
    while (!in_i_ack && n < 50) begin @(negedge clk); n++; end
    ok = in_i_ack;
    row = r; column = c; accumulate = acc; in_i_stb = 1'b1;
    @(negedge clk);
    in_i_stb = 1'b0; row = '0; column = '0; accumulate = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_o_stb && n < 500) begin @(negedge clk); n++; end
    ok = out_o_stb;
  endtask

  task automatic take_out;
    out_o_ack = 1'b1;
    @(negedge clk);
    out_o_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_i_ack !== 1'b0) begin fails++; $display("FAIL rst_in_i_ack: got %b want 0", in_i_ack); end
    checks++; if (out_o_stb !== 1'b0) begin fails++; $display("FAIL rst_out_o_stb: got %b want 0", out_o_stb); end
    checks++; if (out !== F0) begin fails++; $display("FAIL rst_out: got %h want %h", out, F0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b1;
    #1;
    checks++; if (in_i_ack !== 1'b0) begin fails++; $display("FAIL rst_ack_before_edge: got %b want 0", in_i_ack); end
    @(negedge clk);
    checks++; if (in_i_ack !== 1'b1) begin fails++; $display("FAIL rst_ack_after_edge: got %b want 1", in_i_ack); end
  endtask

  task automatic test_basic;
    bit ok;
    start_op(vec4(F1, F2, F3, F4), vec4(F1, F1, F1, F1), 1'b0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_accept: in_i_ack got 0 want 1"); end
    wait_out(ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_timeout: out_o_stb got 0 want 1"); end
    checks++; if (out !== 32'h41200000) begin fails++; $display("FAIL basic_out: got %h want 41200000", out); end
    take_out();
    checks++; if (out_o_stb !== 1'b0) begin fails++; $display("FAIL basic_single_pulse: out_o_stb got %b want 0", out_o_stb); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_accumulate;
    bit ok;
    start_op(vec4(F05, F05, F05, F05), vec4(F2, F2, F2, F2), 1'b1, ok);
    wait_out(ok);
    checks++; if (!ok) begin fails++; $display("FAIL acc_timeout: out_o_stb got 0 want 1"); end
    checks++; if (out !== 32'h41600000) begin fails++; $display("FAIL acc_out: got %h want 41600000", out); end
    take_out();
  endtask

  task automatic test_zero_skip;
    bit ok;
    int m0, a0, s0;
    m0 = mul_txn; a0 = add_txn;
    start_op(vec4(F0, F0, F0, F2), vec4(F5, F5, F5, F3), 1'b0, ok);
    wait_out(ok);
    checks++; if (out !== 32'h40C00000) begin fails++; $display("FAIL skip_out: got %h want 40C00000", out); end
    checks++; if (mul_txn - m0 != 1) begin fails++; $display("FAIL skip_mul_txn: got %0d want 1", mul_txn - m0); end
    checks++; if (add_txn - a0 != 1) begin fails++; $display("FAIL skip_add_txn: got %0d want 1", add_txn - a0); end
    take_out();
    s0 = strobe_cycles;
    start_op(vec4(FN0, F0, FN0, F0), vec4(F5, F5, F5, F3), 1'b1, ok);
    wait_out(ok);
    checks++; if (out !== 32'h40C00000) begin fails++; $display("FAIL skip_all_acc_out: got %h want 40C00000", out); end
    checks++; if (strobe_cycles != s0) begin fails++; $display("FAIL skip_all_acc_strobes: got %0d want 0", strobe_cycles - s0); end
    take_out();
    start_op(vec4(F0, F0, F0, F0), vec4(F1, F2, F3, F4), 1'b0, ok);
    wait_out(ok);
    checks++; if (out !== F0) begin fails++; $display("FAIL skip_all_out: got %h want 00000000", out); end
    checks++; if (strobe_cycles != s0) begin fails++; $display("FAIL skip_all_strobes: got %0d want 0", strobe_cycles - s0); end
    take_out();
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad_out = 0, bad_stb = 0, bad_ack = 0;
    start_op(vec4(F1, F2, F3, F4), vec4(F1, F1, F1, F1), 1'b0, ok);
    wait_out(ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_timeout: out_o_stb got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      in_i_stb = (i % 2 == 0);
      row = vec4(F4, F4, F4, F4); column = vec4(F4, F4, F4, F4);
      @(negedge clk);
      if (out !== 32'h41200000) bad_out++;
      if (out_o_stb !== 1'b1) bad_stb++;
      if (in_i_ack !== 1'b0) bad_ack++;
    end
    in_i_stb = 1'b0; row = '0; column = '0;
    checks++; if (bad_out != 0) begin fails++; $display("FAIL bp_out_stable: %0d unstable cycles want 0", bad_out); end
    checks++; if (bad_stb != 0) begin fails++; $display("FAIL bp_stb_stable: %0d low cycles want 0", bad_stb); end
    checks++; if (bad_ack != 0) begin fails++; $display("FAIL bp_in_ack_low: %0d high cycles want 0", bad_ack); end
    take_out();
    checks++; if (out_o_stb !== 1'b0) begin fails++; $display("FAIL bp_release_stb: got %b want 0", out_o_stb); end
    checks++; if (out !== 32'h41200000) begin fails++; $display("FAIL bp_out_retained: got %h want 41200000", out); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_not_queued: busy got %b want 0", busy); end
    checks++; if (in_i_ack !== 1'b1) begin fails++; $display("FAIL bp_idle_ack: in_i_ack got %b want 1", in_i_ack); end
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    bit found = 0;
    int n = 0, stray = 0;
    start_op(vec4(F1, F2, F3, F4), vec4(F1, F1, F1, F1), 1'b0, ok);
    while (!found && n < 200) begin
      if (dut.state == 3'd3 && dut.k == 5'd2) found = 1;
      else begin @(negedge clk); n++; end
    end
    checks++; if (!found) begin fails++; $display("FAIL midrst_reach_add2: not reached within %0d cycles", n); end
    rst = 1'b0;
    #1;
    checks++; if (out !== F0) begin fails++; $display("FAIL midrst_out: got %h want 00000000", out); end
    checks++; if (out_o_stb !== 1'b0) begin fails++; $display("FAIL midrst_out_o_stb: got %b want 0", out_o_stb); end
    checks++; if (in_i_ack !== 1'b0) begin fails++; $display("FAIL midrst_in_i_ack: got %b want 0", in_i_ack); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_o_stb !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin fails++; $display("FAIL midrst_no_partial: %0d active cycles want 0", stray); end
    start_op(vec4(F1, F2, F3, F4), vec4(F1, F1, F1, F1), 1'b0, ok);
    wait_out(ok);
    checks++; if (out !== 32'h41200000) begin fails++; $display("FAIL midrst_rerun_out: got %h want 41200000", out); end
    take_out();
  endtask

  task automatic test_param_sweep;
    int n = 0;
    while (!iack1 && n < 50) begin @(negedge clk); n++; end
    r1 = F1; c1 = F1; stb1 = 1'b1;
    @(negedge clk);
    stb1 = 1'b0;
    n = 0;
    while (!ostb1 && n < 500) begin @(negedge clk); n++; end
    checks++; if (out1 !== 32'h3F800000) begin fails++; $display("FAIL sweep_n1_out: got %h want 3F800000 stb %b", out1, ostb1); end
    oack1 = 1'b1; @(negedge clk); oack1 = 1'b0;
    n = 0;
    while (!iack16 && n < 50) begin @(negedge clk); n++; end
    r16 = {16{F1}}; c16 = {16{F1}}; stb16 = 1'b1;
    @(negedge clk);
    stb16 = 1'b0;
    n = 0;
    while (!ostb16 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (out16 !== 32'h41800000) begin fails++; $display("FAIL sweep_n16_out: got %h want 41800000 stb %b", out16, ostb16); end
    oack16 = 1'b1; @(negedge clk); oack16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_zero_skip();
    test_backpressure();
    test_reset_mid_op();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
